data_memory_responder: RTL

//  Slave side of the CPU data-memory port. It accepts a CPU load/store request and holds

---
 rtl/data_memory_responder_if.sv | 25 ++
 rtl/data_memory_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/data_memory_responder_if.sv
// CPU data-memory port: request fields from the CPU, stall/fault/load data back.
interface data_memory_responder_if;
  logic        dataMemoryReadEnable;
  logic        dataMemoryWriteEnable;
  logic [31:0] dataMemoryAddress;
  logic [31:0] dataMemoryDataIn;
  logic        dataMemoryReadByte;
  logic        dataMemoryReadHalf;
  logic        dataMemoryReadUnsigned;
  logic [31:0] dataMemoryDataOut;
  logic        dataMemorySuccess;
  logic        dataMemoryFault;

  modport master (
    output dataMemoryReadEnable, dataMemoryWriteEnable, dataMemoryAddress, dataMemoryDataIn,
           dataMemoryReadByte, dataMemoryReadHalf, dataMemoryReadUnsigned,
    input  dataMemoryDataOut, dataMemorySuccess, dataMemoryFault
  );

  modport slave (
    input  dataMemoryReadEnable, dataMemoryWriteEnable, dataMemoryAddress, dataMemoryDataIn,
           dataMemoryReadByte, dataMemoryReadHalf, dataMemoryReadUnsigned,
    output dataMemoryDataOut, dataMemorySuccess, dataMemoryFault
  );
endinterface

// File: rtl/data_memory_responder.sv
// Multi-cycle word RAM behind the CPU data port: byte/half/word sizing, load extension,
// fault detection and a fixed-latency stall handshake.
module data_memory_responder_lane #(
  parameter int VEC_W = 8
) (
  input  logic             en,
  input  logic [VEC_W-1:0] oldLane,
  input  logic [VEC_W-1:0] newLane,
  output logic [VEC_W-1:0] mergedLane
);
  assign mergedLane = en ? newLane : oldLane;
endmodule

module data_memory_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic                     clk,
  input logic                     rst,
  data_memory_responder_if.slave  bus
);
  localparam int         NUM_LANES = 4;
  localparam int         VEC_W     = 8;
  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT       = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic        isByte;
    logic        isHalf;
    logic        isUnsigned;
  } req_t;

  state_t      state, nextState;
  req_t        reqIn, reqLat;
  logic        req, success, enterRespond;
  logic [3:0]  cnt;
  logic [31:0] dataOutR;
  logic        faultR;
  logic [31:0] mem [DEPTH_WORDS];

  assign req   = bus.dataMemoryReadEnable | bus.dataMemoryWriteEnable;
  assign reqIn = '{write:      bus.dataMemoryWriteEnable,
                   addr:       bus.dataMemoryAddress,
                   data:       bus.dataMemoryDataIn,
                   isByte:     bus.dataMemoryReadByte,
                   isHalf:     bus.dataMemoryReadHalf,
                   isUnsigned: bus.dataMemoryReadUnsigned};

  // In IDLE decode the live request so a zero-latency access can read on the accepting edge.
  logic [31:0] curAddr, offset, rdWord, loadData;
  logic        curByte, curHalf, curUns, misaligned, outOfRange, fault;
  logic [IDX_W-1:0] idx;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign curAddr = (state == IDLE) ? reqIn.addr       : reqLat.addr;
  assign curByte = (state == IDLE) ? reqIn.isByte     : reqLat.isByte;
  assign curHalf = (state == IDLE) ? reqIn.isHalf     : reqLat.isHalf;
  assign curUns  = (state == IDLE) ? reqIn.isUnsigned : reqLat.isUnsigned;

  assign offset     = curAddr - BASE_ADDR;
  assign misaligned = curByte ? 1'b0 : curHalf ? curAddr[0] : (curAddr[1:0] != 2'b00);
  assign outOfRange = (curAddr < BASE_ADDR) || ((offset >> 2) >= 32'(DEPTH_WORDS));
  assign fault      = misaligned | outOfRange;
  assign idx        = offset[IDX_W+1:2];
  assign rdWord     = mem[idx];

  assign byteSel = rdWord[{curAddr[1:0], 3'b000} +: 8];
  assign halfSel = rdWord[{curAddr[1], 4'b0000} +: 16];

  always_comb begin
    loadData = rdWord;
    if (curByte)      loadData = {{24{~curUns & byteSel[7]}}, byteSel};
    else if (curHalf) loadData = {{16{~curUns & halfSel[15]}}, halfSel};
  end

  // Store path: sub-word data replicated across lanes, byte enables pick the touched lanes.
  logic [NUM_LANES-1:0][VEC_W-1:0] oldLanes, newLanes, wrLanes;
  logic [NUM_LANES-1:0]            laneEn;

  assign oldLanes = rdWord;
  assign newLanes = reqLat.isByte ? {NUM_LANES{reqLat.data[7:0]}} :
                    reqLat.isHalf ? {2{reqLat.data[15:0]}} : reqLat.data;

  for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
    assign laneEn[l] = reqLat.isByte ? (reqLat.addr[1:0] == 2'(l)) :
                       reqLat.isHalf ? (reqLat.addr[1] == 1'(l >> 1)) : 1'b1;
    data_memory_responder_lane #(.VEC_W(VEC_W)) uLane (
      .en        (laneEn[l]),
      .oldLane   (oldLanes[l]),
      .newLane   (newLanes[l]),
      .mergedLane(wrLanes[l])
    );
  end

  always_comb begin
    nextState = state;
    success   = 1'b0;
    unique case (state)
      IDLE: begin
        success = ~req;
        if (req) nextState = (LAT == 4'd0) ? RESPOND : WAIT;
      end
      WAIT:    if (cnt <= 4'd1) nextState = RESPOND;
      RESPOND: begin
        success   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign enterRespond = (nextState == RESPOND) && (state != RESPOND);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 4'd0;
      dataOutR <= 32'h0;
      faultR   <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        reqLat <= reqIn;
        cnt    <= LAT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      faultR <= enterRespond & fault;
      if (enterRespond) dataOutR <= fault ? 32'h0 : loadData;
    end
  end

  // RAM is never cleared; a reset in RESPOND suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && state == RESPOND && reqLat.write && !faultR) mem[idx] <= wrLanes;
  end

  assign bus.dataMemoryDataOut = dataOutR;
  assign bus.dataMemorySuccess = success;
  assign bus.dataMemoryFault   = faultR;
endmodule
